// File: rtl/gtxe2_chnl_rx_oob.sv
// Receive-side SATA OOB detector: measures burst/gap run lengths on the squelch
// indication and flags complete COMWAKE or COMINIT sequences with one-cycle pulses.
module gtxe2_chnl_rx_oob #(
  parameter int         CNT_W              = 8,
  parameter logic [3:0] SATA_BURST_SEQ_LEN = 4'b0100,
  parameter int         BURST_MIN          = 10,
  parameter int         BURST_MAX          = 22,
  parameter int         WAKE_GAP_MIN       = 9,
  parameter int         WAKE_GAP_MAX       = 26,
  parameter int         INIT_GAP_MIN       = 27,
  parameter int         INIT_GAP_MAX       = 78
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_idle,
  output logic RXCOMWAKEDET,
  output logic RXCOMINITDET,
  output logic oob_busy
);

  localparam logic [CNT_W-1:0] BURST_MIN_C    = CNT_W'(BURST_MIN);
  localparam logic [CNT_W-1:0] BURST_MAX_C    = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] WAKE_GAP_MIN_C = CNT_W'(WAKE_GAP_MIN);
  localparam logic [CNT_W-1:0] WAKE_GAP_MAX_C = CNT_W'(WAKE_GAP_MAX);
  localparam logic [CNT_W-1:0] INIT_GAP_MIN_C = CNT_W'(INIT_GAP_MIN);
  localparam logic [CNT_W-1:0] INIT_GAP_MAX_C = CNT_W'(INIT_GAP_MAX);
  localparam logic [CNT_W-1:0] ONE_C          = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_BURST, ST_GAP, ST_ABORT, ST_HOLDOFF
  } state_e;

  typedef enum logic [1:0] {
    GAP_NONE, GAP_WAKE, GAP_INIT, GAP_BAD
  } gap_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lenCnt_q, lenCnt_d;
  logic [3:0]       burstCnt_q, burstCnt_d;
  gap_e             gapType_q, gapType_d;
  logic             wakeDet_q, wakeDet_d;
  logic             initDet_q, initDet_d;
  logic             busy_q;

  logic [CNT_W-1:0] lenInc;
  logic [3:0]       burstInc;
  logic             burstOk;
  gap_e             gapClass;

  assign lenInc   = (&lenCnt_q) ? lenCnt_q : lenCnt_q + ONE_C;
  assign burstInc = burstCnt_q + 4'd1;
  assign burstOk  = (lenCnt_q >= BURST_MIN_C) && (lenCnt_q <= BURST_MAX_C);

  always_comb begin
    gapClass = GAP_BAD;
    if ((lenCnt_q >= WAKE_GAP_MIN_C) && (lenCnt_q <= WAKE_GAP_MAX_C))
      gapClass = GAP_WAKE;
    else if ((lenCnt_q >= INIT_GAP_MIN_C) && (lenCnt_q <= INIT_GAP_MAX_C))
      gapClass = GAP_INIT;
  end

  always_comb begin
    state_d    = state_q;
    lenCnt_d   = lenCnt_q;
    burstCnt_d = burstCnt_q;
    gapType_d  = gapType_q;
    wakeDet_d  = 1'b0;
    initDet_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_idle) begin
          state_d    = ST_BURST;
          lenCnt_d   = ONE_C;
          burstCnt_d = 4'd0;
          gapType_d  = GAP_NONE;
        end
      end
      ST_BURST: begin
        if (!rx_idle) begin
          if (lenInc > BURST_MAX_C) state_d = ST_ABORT;
          else                      lenCnt_d = lenInc;
        end else if (burstOk) begin
          burstCnt_d = burstInc;
          lenCnt_d   = ONE_C;
          if (burstInc == SATA_BURST_SEQ_LEN) begin
            wakeDet_d = (gapType_q == GAP_WAKE);
            initDet_d = (gapType_q == GAP_INIT);
            state_d   = ST_HOLDOFF;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (rx_idle) begin
          if (lenInc > INIT_GAP_MAX_C) state_d = ST_IDLE;
          else                         lenCnt_d = lenInc;
        end else begin
          state_d  = ST_BURST;
          lenCnt_d = ONE_C;
          // A bad or inconsistent gap restarts counting with this burst as the first.
          if (gapClass == GAP_BAD || (gapType_q != GAP_NONE && gapClass != gapType_q)) begin
            burstCnt_d = 4'd0;
            gapType_d  = GAP_NONE;
          end else begin
            gapType_d = gapClass;
          end
        end
      end
      ST_ABORT: begin
        if (rx_idle) state_d = ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (rx_idle) begin
          if (lenInc > INIT_GAP_MAX_C) state_d = ST_IDLE;
          else                         lenCnt_d = lenInc;
        end else begin
          lenCnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lenCnt_q   <= '0;
      burstCnt_q <= 4'd0;
      gapType_q  <= GAP_NONE;
      wakeDet_q  <= 1'b0;
      initDet_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lenCnt_q   <= lenCnt_d;
      burstCnt_q <= burstCnt_d;
      gapType_q  <= gapType_d;
      wakeDet_q  <= wakeDet_d;
      initDet_q  <= initDet_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign RXCOMWAKEDET = wakeDet_q;
  assign RXCOMINITDET = initDet_q;
  assign oob_busy     = busy_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_oob.sv
// Scoreboard bench for the RX OOB detector: stimulus queues expected pulses with
// the clock edge they must appear on; a monitor pops and compares each pulse.
module tb_gtxe2_chnl_rx_oob;

  localparam int K_NONE = 0;
  localparam int K_WAKE = 1;
  localparam int K_INIT = 2;

  typedef struct {
    int kind;
    int edgeNum;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rx_idle = 1'b1;
  logic RXCOMWAKEDET;
  logic RXCOMINITDET;
  logic oob_busy;

  int   total     = 0;
  int   bad       = 0;
  int   edgeCount = 0;
  exp_t sbQ[$];

  gtxe2_chnl_rx_oob dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_idle      (rx_idle),
    .RXCOMWAKEDET (RXCOMWAKEDET),
    .RXCOMINITDET (RXCOMINITDET),
    .oob_busy     (oob_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edgeCount);
    end
  endtask

  // Every pulse seen must match the oldest queued expectation in kind and edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (RXCOMWAKEDET && RXCOMINITDET) begin
        checkOutput("both_pulses", 1, 0);
      end else if (RXCOMWAKEDET || RXCOMINITDET) begin
        int   kind;
        exp_t e;
        kind = RXCOMWAKEDET ? K_WAKE : K_INIT;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_pulse", kind, K_NONE);
        end else begin
          e = sbQ.pop_front();
          checkOutput("pulse_kind", kind, e.kind);
          checkOutput("pulse_edge", edgeCount, e.edgeNum);
        end
      end
    end
  end

  task automatic applyStimulus(input logic v);
    rx_idle = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sendActive(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  task automatic sendIdle(input int n, input int expKind);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && expKind != K_NONE) begin
        exp_t e;
        e.kind    = expKind;
        e.edgeNum = edgeCount + 1;
        sbQ.push_back(e);
      end
      applyStimulus(1'b1);
    end
  endtask

  // Bursts bl[i] separated by gaps gl[i]; 100 idle cycles follow the last burst.
  task automatic runSeq(input string name, input int nb, input int bl[8], input int gl[8],
                        input int expKind, input int detAt);
    for (int b = 0; b < nb; b++) begin
      sendActive(bl[b]);
      sendIdle((b < nb - 1) ? gl[b] : 100, (b + 1 == detAt) ? expKind : K_NONE);
    end
    checkOutput({name, "_sb_empty"}, sbQ.size(), 0);
    checkOutput({name, "_busy_end"}, int'(oob_busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wake", int'(RXCOMWAKEDET), 0);
    checkOutput("reset_init", int'(RXCOMINITDET), 0);
    checkOutput("reset_busy", int'(oob_busy), 0);
    reset_n = 1'b1;
    sendIdle(2, K_NONE);

    // Basic COMWAKE, with busy checked while in holdoff
    for (int b = 0; b < 4; b++) begin
      sendActive(16);
      if (b < 3) sendIdle(16, K_NONE);
    end
    sendIdle(20, K_WAKE);
    checkOutput("wake_busy_holdoff", int'(oob_busy), 1);
    sendIdle(80, K_NONE);
    checkOutput("wake_sb_empty", sbQ.size(), 0);
    checkOutput("wake_busy_end", int'(oob_busy), 0);

    // COMINIT of 6 bursts; busy drops on the 79th trailing idle
    for (int b = 0; b < 6; b++) begin
      sendActive(16);
      if (b < 5) sendIdle(48, (b == 3) ? K_INIT : K_NONE);
    end
    sendIdle(78, K_NONE);
    checkOutput("init_busy_78", int'(oob_busy), 1);
    sendIdle(1, K_NONE);
    checkOutput("init_busy_79", int'(oob_busy), 0);
    sendIdle(21, K_NONE);
    checkOutput("init_sb_empty", sbQ.size(), 0);

    runSeq("gap26", 4, '{16,16,16,16,0,0,0,0}, '{26,26,26,0,0,0,0,0}, K_WAKE, 4);
    runSeq("gap27", 4, '{16,16,16,16,0,0,0,0}, '{27,27,27,0,0,0,0,0}, K_INIT, 4);
    runSeq("mixed", 6, '{16,16,16,16,16,16,0,0}, '{16,48,16,48,16,0,0,0}, K_NONE, 0);
    runSeq("edges", 4, '{10,22,10,22,0,0,0,0}, '{9,9,9,0,0,0,0,0}, K_WAKE, 4);
    runSeq("gap78", 4, '{16,16,16,16,0,0,0,0}, '{78,78,78,0,0,0,0,0}, K_INIT, 4);
    runSeq("abort", 7, '{16,16,30,16,16,16,16,0}, '{16,16,16,16,16,16,0,0}, K_WAKE, 7);
    runSeq("short", 6, '{16,9,16,16,16,16,0,0}, '{16,16,16,16,16,0,0,0}, K_WAKE, 6);
    runSeq("gap100", 6, '{16,16,16,16,16,16,0,0}, '{16,100,16,16,16,0,0,0}, K_WAKE, 6);

    // Reset in the middle of a COMINIT sequence discards progress
    for (int b = 0; b < 3; b++) begin
      sendActive(16);
      if (b < 2) sendIdle(48, K_NONE);
    end
    sendIdle(20, K_NONE);
    checkOutput("rst_busy_before", int'(oob_busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_wake", int'(RXCOMWAKEDET), 0);
    checkOutput("rst_init", int'(RXCOMINITDET), 0);
    checkOutput("rst_busy", int'(oob_busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sendIdle(28, K_NONE);
    sendActive(16);
    sendIdle(100, K_NONE);
    checkOutput("rst_sb_empty", sbQ.size(), 0);
    checkOutput("rst_busy_end", int'(oob_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
